// File: rtl/uart_rx_cmd_ctrl.sv
// Assembles 4-byte UART command frames (SYNC, ADDR, DATA, CHK) and issues one-cycle register writes.
// Optional inter-byte timeout is enabled by defining UART_CMD_TIMEOUT_EN.
module uart_rx_cmd_ctrl #(
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter int unsigned ADDR_W         = 4,
   parameter int unsigned CNT_W          = 8,
   parameter int unsigned TIMEOUT_CYCLES = 104160
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [7:0]        i_rx_byte,
   input  logic              i_rx_done,
   input  logic              i_rx_err,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [7:0]        o_wr_data,
   output logic              o_frame_err,
   output logic              o_busy,
   output logic [CNT_W-1:0]  o_ok_cnt,
   output logic [CNT_W-1:0]  o_err_cnt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GOT_SYNC = 2'd1,
      GOT_ADDR = 2'd2,
      GOT_DATA = 2'd3
   } state_t;

   // Elaboration-time parameter sanity checks
   if (ADDR_W < 1 || ADDR_W > 8) begin : g_bad_addr_w
      $error("uart_rx_cmd_ctrl: ADDR_W must be in 1..8");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("uart_rx_cmd_ctrl: TIMEOUT_CYCLES must be at least 2");
   end

   state_t              state_q, state_d;
   logic [7:0]          addr_q, addr_d;
   logic [7:0]          data_q, data_d;
   logic                wr_en_q, wr_en_d;
   logic                frame_err_q, frame_err_d;
   logic                busy_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [7:0]          wr_data_q;
   logic [CNT_W-1:0]    ok_cnt_q, err_cnt_q;
   logic                chk_ok_c;
   logic                timeout_c;

   // Checksum must match and the address byte must not use bits above ADDR_W
   assign chk_ok_c = (i_rx_byte == (SYNC_BYTE ^ addr_q ^ data_q)) &&
                     ((addr_q >> ADDR_W) == 8'd0);

`ifdef UART_CMD_TIMEOUT_EN
   localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_q;

   // Inter-byte silence counter, only meaningful inside a frame
   always_ff @(posedge i_clk) begin
      if (i_rst || state_q == IDLE || i_rx_done) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + TMO_W'(1);
      end
   end

   // An arriving byte takes priority over expiry in the same cycle
   assign timeout_c = (state_q != IDLE) && !i_rx_done && (tmo_q == TMO_LAST);
`else
   assign timeout_c = 1'b0;
`endif

   // Next-state and strobe decode
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      data_d      = data_q;
      wr_en_d     = 1'b0;
      frame_err_d = 1'b0;
      if (i_rx_done) begin
         if (i_rx_err) begin
            if (state_q != IDLE) begin
               state_d     = IDLE;
               frame_err_d = 1'b1;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (i_rx_byte == SYNC_BYTE) state_d = GOT_SYNC;
               end
               GOT_SYNC: begin
                  addr_d  = i_rx_byte;
                  state_d = GOT_ADDR;
               end
               GOT_ADDR: begin
                  data_d  = i_rx_byte;
                  state_d = GOT_DATA;
               end
               GOT_DATA: begin
                  state_d = IDLE;
                  if (chk_ok_c) wr_en_d     = 1'b1;
                  else          frame_err_d = 1'b1;
               end
               default: state_d = IDLE;
            endcase
         end
      end else if (timeout_c) begin
         state_d     = IDLE;
         frame_err_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         data_q      <= '0;
         wr_en_q     <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         ok_cnt_q    <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         wr_en_q     <= wr_en_d;
         frame_err_q <= frame_err_d;
         busy_q      <= (state_d != IDLE);
         if (wr_en_d) begin
            wr_addr_q <= addr_q[ADDR_W-1:0];
            wr_data_q <= data_q;
            if (ok_cnt_q != '1) ok_cnt_q <= ok_cnt_q + CNT_W'(1);
         end
         if (frame_err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

   assign o_wr_en     = wr_en_q;
   assign o_wr_addr   = wr_addr_q;
   assign o_wr_data   = wr_data_q;
   assign o_frame_err = frame_err_q;
   assign o_busy      = busy_q;
   assign o_ok_cnt    = ok_cnt_q;
   assign o_err_cnt   = err_cnt_q;

endmodule
